fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Program-fetch controller for the 8-bit lab CPU.
- Owns the program counter and drives the address of the combinational instruction memory.
- Registers each fetched byte and presents it to decode/execute through a valid/ready handshake.
- Supports free-run, single-step, jumps, halt request, and end-of-program detection.

Parameters:
ADDR_W, 8, width of program counter and imem address
DATA_W, 8, instruction width
PROG_LEN, 12, number of valid program words; reaching pc >= PROG_LEN halts
START_ADDR, 0, pc value after reset or restart

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-low reset
run  input  1  level; continuous fetching while high
step  input  1  one-cycle pulse; fetch/issue exactly one instruction
halt_req  input  1  one-cycle pulse; stop after current instruction
restart  input  1  one-cycle pulse; leave HALT, pc <= START_ADDR
imem_addr  output  ADDR_W  address to instruction memory (= pc, combinational)
imem_data  input  DATA_W  instruction word from memory
instr  output  DATA_W  registered instruction to decode
instr_valid  output  1  instr holds an unaccepted instruction
instr_ready  input  1  decode accepts instr this cycle
jump_valid  input  1  qualifies jump_target; sampled only on accept
jump_target  input  ADDR_W  next pc when jump_valid on accept
pc  output  ADDR_W  current program counter
busy  output  1  high in FETCH or ISSUE
done  output  1  high in HALT

Behaviour:
Reset:
- clear low forces, asynchronously, state=IDLE, pc=START_ADDR, instr=0, instr_valid=0, done=0, busy=0, halt_pend=0, single=0.
- Reset mid-operation discards any pending instruction.

States and transitions:
- IDLE: run -> FETCH. step -> FETCH with single=1. halt_req -> HALT. halt_req wins over run/step.
- FETCH (1 cycle): instr <= imem_data; instr_valid <= 1 -> ISSUE.
- ISSUE: instr and instr_valid are held stable until instr_ready=1. On the accept cycle:
  - next_pc = jump_valid ? jump_target : pc+1 (mod 2^ADDR_W).
  - pc <= next_pc; instr_valid <= 0.
  - Next state, first match wins: halt_pend, halt_req, or next_pc >= PROG_LEN -> HALT; single=1 or run=0 -> PAUSE (clear single); else FETCH.
- PAUSE: pc retained. run -> FETCH. step -> FETCH with single=1. halt_req -> HALT.
- HALT: done=1. Ignores run and step. restart -> IDLE with pc=START_ADDR, done=0, halt_pend=0.

halt_req and jump rules:
- halt_req in FETCH, or in ISSUE without accept, sets halt_pend.
- An issued instruction is never dropped.
- jump_valid and jump_target are ignored except on the accept cycle.

Timing and arithmetic:
- Latency: run rises in IDLE at cycle 0 -> FETCH cycle 1 -> instr_valid=1 with mem[START_ADDR] at cycle 2.
- Peak throughput with instr_ready held high: one instruction per 2 cycles.
- PROG_LEN compare is unsigned. Increment wraps 255 -> 0; 0 is then compared against PROG_LEN normally.
- Simultaneous restart and halt_req in HALT: restart wins.
- step while run=1: treated as run (single not set).

Test Plan:
- Free run, mem[0..11] = 45,59,18,5C,0D,B4,60,1B,8C,48,2C,C3, run=1, ready=1 -> instr sequence 0x45,0x59,…,0xC3 on alternate cycles; after the 0xC3 accept, pc=12, done=1, busy=0.
- Backpressure: ready=0 for 5 cycles while instr=0x45 -> instr_valid stays high, instr stays 0x45, pc stays 0; ready=1 -> pc=1, next instr 0x59.
- Single step: three step pulses from IDLE -> exactly 0x45, 0x59, 0x18 issued, each followed by PAUSE, pc=3, busy=0.
- Jump: accept at pc=2 with jump_valid=1, target=9 -> next instr 0x48, pc=9; target=20 -> HALT with pc=20.
- halt_req during FETCH at pc=4 -> 0x0D still issued and accepted, then HALT with pc=5; restart -> IDLE, pc=0; run -> 0x45.
- clear pulsed low while instr_valid=1 at pc=6 -> instr_valid=0, pc=0, state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Program-fetch controller for the 8-bit lab CPU. Owns the program counter,
// drives the combinational instruction-memory address, registers each fetched
// word and offers it to decode through a valid/ready handshake. Supports
// free-run, single-step, jumps on accept, halt requests and end-of-program
// detection (pc >= PROG_LEN).
//
// Ports:
//   clk          rising-edge clock
//   clear        asynchronous active-low reset
//   run          level, continuous fetching while high
//   step         pulse, fetch/issue exactly one instruction
//   halt_req     pulse, stop after the current instruction
//   restart      pulse, leave HALT and reload pc with START_ADDR
//   imem_addr    instruction memory address (= pc)
//   imem_data    instruction word from memory
//   instr        registered instruction to decode
//   instr_valid  instr holds an unaccepted instruction
//   instr_ready  decode accepts instr this cycle
//   jump_valid   qualifies jump_target, sampled only on accept
//   jump_target  next pc when jump_valid on accept
//   pc           current program counter
//   busy         high while fetching or issuing
//   done         high while halted
module fetch_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int PROG_LEN   = 12,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              restart,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_PAUSE,
    S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] START_PC   = ADDR_W'(START_ADDR);
  localparam logic [31:0]       PROG_LEN_W = 32'(PROG_LEN);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [DATA_W-1:0]   instr_reg, instr_next;
  logic                valid_reg, valid_next;
  logic                halt_pend_reg, halt_pend_next;
  logic                single_reg, single_next;

  logic [ADDR_W-1:0]   target_pc;
  logic                past_end;

  // Candidate pc for the accept cycle; increment wraps naturally at 2^ADDR_W.
  assign target_pc = jump_valid ? jump_target : pc_reg + ADDR_W'(1);
  // Unsigned compare of the candidate pc against the program length.
  assign past_end  = {{(32-ADDR_W){1'b0}}, target_pc} >= PROG_LEN_W;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg     <= S_IDLE;
      pc_reg        <= START_PC;
      instr_reg     <= '0;
      valid_reg     <= 1'b0;
      halt_pend_reg <= 1'b0;
      single_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      valid_reg     <= valid_next;
      halt_pend_reg <= halt_pend_next;
      single_reg    <= single_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    valid_next     = valid_reg;
    halt_pend_next = halt_pend_reg;
    single_next    = single_reg;

    case (state_reg)
      // IDLE and PAUSE react to commands identically; they differ only in
      // how they were entered. halt_req has priority, and run overrides step.
      S_IDLE, S_PAUSE: begin
        if (halt_req) begin
          state_next = S_HALT;
        end else if (run) begin
          state_next  = S_FETCH;
          single_next = 1'b0;
        end else if (step) begin
          state_next  = S_FETCH;
          single_next = 1'b1;
        end
      end

      S_FETCH: begin
        instr_next = imem_data;
        valid_next = 1'b1;
        state_next = S_ISSUE;
        // The word being fetched is still issued; remember the halt for later.
        if (halt_req) halt_pend_next = 1'b1;
      end

      S_ISSUE: begin
        if (instr_ready) begin
          pc_next    = target_pc;
          valid_next = 1'b0;
          if (halt_pend_reg || halt_req || past_end) begin
            state_next  = S_HALT;
            single_next = 1'b0;
          end else if (single_reg || !run) begin
            state_next  = S_PAUSE;
            single_next = 1'b0;
          end else begin
            state_next = S_FETCH;
          end
        end else if (halt_req) begin
          halt_pend_next = 1'b1;
        end
      end

      S_HALT: begin
        if (restart) begin
          state_next     = S_IDLE;
          pc_next        = START_PC;
          halt_pend_next = 1'b0;
          single_next    = 1'b0;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign busy        = (state_reg == S_FETCH) || (state_reg == S_ISSUE);
  assign done        = (state_reg == S_HALT);

endmodule
